// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - receive-side blink waveform checker: period/high-time measurement, lock and sticky error
module blink_monitor #(
   parameter int CNT_W      = 8,
   parameter int EXP_PERIOD = 8,
   parameter int TOL        = 0,
   parameter int LOCK_CNT   = 3,
   parameter int TIMEOUT    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             blink_in,
   input  logic             err_clr,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] C_MAX     = '1;
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   C_EXP     = (CNT_W+1)'(EXP_PERIOD);
   localparam logic [CNT_W:0]   C_TOL     = (CNT_W+1)'(TOL);
   localparam logic [MC_W-1:0]  C_MC_ONE  = MC_W'(1);
   localparam logic [MC_W-1:0]  C_LOCK    = MC_W'(LOCK_CNT);

   state_t            r_state;
   logic              r_blink_q;
   logic [CNT_W-1:0]  r_per_cnt;
   logic [CNT_W-1:0]  r_high_cnt;
   logic [MC_W-1:0]   r_match_cnt;

   logic              w_rise;
   logic [CNT_W:0]    w_per_ext;
   logic [CNT_W:0]    w_diff;
   logic              w_match;
   logic [CNT_W-1:0]  w_per_inc;
   logic [CNT_W-1:0]  w_high_inc;
   logic [MC_W-1:0]   w_match_nxt;

   assign w_rise      = blink_in & ~r_blink_q;
   assign w_per_ext   = {1'b0, r_per_cnt};
   assign w_diff      = (w_per_ext >= C_EXP) ? (w_per_ext - C_EXP) : (C_EXP - w_per_ext);
   assign w_match     = (w_diff <= C_TOL);
   assign w_per_inc   = (r_per_cnt == C_MAX) ? r_per_cnt : (r_per_cnt + C_ONE);
   assign w_high_inc  = ((r_high_cnt == C_MAX) || !blink_in) ? r_high_cnt : (r_high_cnt + C_ONE);
   assign w_match_nxt = r_match_cnt + C_MC_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_blink_q    <= 1'b0;
         r_per_cnt    <= '0;
         r_high_cnt   <= '0;
         r_match_cnt  <= '0;
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         err          <= 1'b0;
      end else begin
         r_blink_q    <= blink_in;
         period_valid <= 1'b0;
         // a new error assigned later in this block wins over err_clr
         if (err_clr) begin
            err <= 1'b0;
         end
         if (!en) begin
            r_state     <= IDLE;
            locked      <= 1'b0;
            r_per_cnt   <= '0;
            r_high_cnt  <= '0;
            r_match_cnt <= '0;
         end else begin
            case (r_state)
               IDLE: r_state <= WAIT_EDGE;
               WAIT_EDGE: begin
                  if (w_rise) begin
                     r_state     <= MEASURE;
                     r_per_cnt   <= C_ONE;
                     r_high_cnt  <= C_ONE;
                     r_match_cnt <= '0;
                  end
               end
               MEASURE, LOCKED: begin
                  if (w_rise) begin
                     r_per_cnt    <= C_ONE;
                     r_high_cnt   <= C_ONE;
                     period       <= r_per_cnt;
                     high_time    <= r_high_cnt;
                     period_valid <= 1'b1;
                     if (w_match) begin
                        if (r_state == MEASURE) begin
                           r_match_cnt <= w_match_nxt;
                           if (w_match_nxt == C_LOCK) begin
                              r_state <= LOCKED;
                              locked  <= 1'b1;
                           end
                        end
                     end else begin
                        r_match_cnt <= '0;
                        err         <= 1'b1;
                        locked      <= 1'b0;
                        r_state     <= MEASURE;
                     end
                  end else if (r_per_cnt == C_TIMEOUT) begin
                     err         <= 1'b1;
                     locked      <= 1'b0;
                     r_state     <= WAIT_EDGE;
                     r_per_cnt   <= '0;
                     r_high_cnt  <= '0;
                     r_match_cnt <= '0;
                  end else begin
                     r_per_cnt  <= w_per_inc;
                     r_high_cnt <= w_high_inc;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - randomized bench for blink_monitor against a cycle-count reference model
module tb_blink_monitor;

   localparam int CNT_W      = 8;
   localparam int EXP_PERIOD = 8;
   localparam int TOL        = 0;
   localparam int LOCK_CNT   = 3;
   localparam int TIMEOUT    = 32;
   localparam int SAT_MAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             blink_in;
   logic             err_clr;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             period_valid;
   logic             locked;
   logic             err;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   int p0 = 0;
   bit rnd_clr = 1'b0;

   blink_monitor #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL),
      .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .blink_in(blink_in), .err_clr(err_clr),
      .period(period), .high_time(high_time), .period_valid(period_valid),
      .locked(locked), .err(err)
   );

   always #5 clk = ~clk;

   // Reference: mode 0 off, 1 waiting for first rise, 2 tracking rises by absolute cycle number
   int m_mode = 0, m_cyc = 0, m_last = 0, m_highs = 0, m_streak = 0;
   bit m_prev = 1'b0, m_pv = 1'b0, m_lock = 1'b0, m_err = 1'b0;
   int m_period = 0, m_high = 0;

   function automatic int sat(input int v);
      return (v > SAT_MAX) ? SAT_MAX : v;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit rise, fault;
      int k, d;
      if (!rst_n) begin
         m_mode = 0; m_last = 0; m_highs = 0; m_streak = 0;
         m_prev = 1'b0; m_pv = 1'b0; m_lock = 1'b0; m_err = 1'b0;
         m_period = 0; m_high = 0;
      end else begin
         rise   = blink_in && !m_prev;
         m_prev = blink_in;
         m_cyc++;
         m_pv   = 1'b0;
         fault  = 1'b0;
         if (!en) begin
            m_mode = 0; m_streak = 0; m_lock = 1'b0;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            if (rise) begin
               m_mode = 2; m_last = m_cyc; m_highs = 1; m_streak = 0;
            end
         end else begin
            k = m_cyc - m_last;
            if (rise) begin
               m_period = sat(k);
               m_high   = sat(m_highs);
               m_pv     = 1'b1;
               d = sat(k) - EXP_PERIOD;
               if (d < 0) d = -d;
               if (d <= TOL) begin
                  m_streak++;
                  if (m_streak >= LOCK_CNT) m_lock = 1'b1;
               end else begin
                  m_streak = 0; m_lock = 1'b0; fault = 1'b1;
               end
               m_last = m_cyc; m_highs = 1;
            end else if (k == TIMEOUT) begin
               fault = 1'b1; m_lock = 1'b0; m_mode = 1; m_streak = 0;
            end else if (blink_in) begin
               m_highs++;
            end
         end
         m_err = (m_err && !err_clr) || fault;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         cmp("period", 32'(period), 32'(m_period));
         cmp("high_time", 32'(high_time), 32'(m_high));
         cmp("period_valid", 32'(period_valid), 32'(m_pv));
         cmp("locked", 32'(locked), 32'(m_lock));
         cmp("err", 32'(err), 32'(m_err));
      end
      if (period_valid === 1'b1) pulses++;
   end

   task automatic blink(input bit v, input int n);
      repeat (n) begin
         @(negedge clk);
         blink_in = v;
         err_clr  = rnd_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; blink_in = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      cmp("rst_period", 32'(period), 0);
      cmp("rst_high", 32'(high_time), 0);
      cmp("rst_pv", 32'(period_valid), 0);
      cmp("rst_locked", 32'(locked), 0);
      cmp("rst_err", 32'(err), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); en = 1'b1;

      // steady 4h/4l: lock on the third pulse
      repeat (5) begin blink(1, 4); blink(0, 4); end
      blink(1, 1); blink(1, 1); #2;
      cmp("t1_period", 32'(period), 8);
      cmp("t1_high", 32'(high_time), 4);
      cmp("t1_pv", 32'(period_valid), 1);
      cmp("t1_locked", 32'(locked), 1);
      cmp("t1_err", 32'(err), 0);
      cmp("t1_pulses", 32'(pulses), 5);
      blink(1, 2); blink(0, 4);

      // one long period breaks lock, three good ones restore it
      blink(1, 5); blink(0, 5); blink(1, 1); blink(1, 1); #2;
      cmp("t2_period", 32'(period), 10);
      cmp("t2_high", 32'(high_time), 5);
      cmp("t2_locked", 32'(locked), 0);
      cmp("t2_err", 32'(err), 1);
      blink(1, 2); blink(0, 4);
      repeat (2) begin blink(1, 4); blink(0, 4); end
      blink(1, 1); blink(1, 1); #2;
      cmp("t2_relock", 32'(locked), 1);
      cmp("t2_err_sticky", 32'(err), 1);

      // err_clr alone, then err_clr colliding with a bad capture
      blink(1, 2);
      @(negedge clk); blink_in = 1'b0; err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; #2;
      cmp("t4_clr", 32'(err), 0);
      blink(0, 2);
      blink(1, 3); blink(0, 3);
      @(negedge clk); blink_in = 1'b1; err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; #2;
      cmp("t4_collide_err", 32'(err), 1);
      cmp("t4_period", 32'(period), 6);
      cmp("t4_locked", 32'(locked), 0);
      blink(1, 2);
      @(negedge clk); blink_in = 1'b0; err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; #2;
      cmp("t4_clr2", 32'(err), 0);
      blink(0, 2);

      // loss of signal while locked
      repeat (3) begin blink(1, 4); blink(0, 4); end
      blink(1, 4); #2;
      cmp("t3_pre_locked", 32'(locked), 1);
      cmp("t3_pre_err", 32'(err), 0);
      blink(0, 40); #2;
      cmp("t3_err", 32'(err), 1);
      cmp("t3_locked", 32'(locked), 0);
      p0 = pulses;
      blink(1, 4); blink(0, 4); blink(1, 1); blink(1, 1); #2;
      cmp("t3_pulses", 32'(pulses - p0), 1);
      cmp("t3_period", 32'(period), 8);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      blink(0, 4);

      // enable drop while locked
      repeat (2) begin blink(1, 4); blink(0, 4); end
      blink(1, 1); blink(1, 1); #2;
      cmp("t6_locked", 32'(locked), 1);
      @(negedge clk); en = 1'b0;
      @(negedge clk); en = 1'b1; #2;
      cmp("t6_unlock", 32'(locked), 0);
      cmp("t6_pv", 32'(period_valid), 0);
      blink(0, 4); #2;
      p0 = pulses;
      repeat (3) begin blink(1, 4); blink(0, 4); end
      blink(1, 1); blink(1, 1); #2;
      cmp("t6_pulses", 32'(pulses - p0), 3);
      cmp("t6_relock", 32'(locked), 1);

      // asynchronous reset mid-period
      blink(1, 2);
      #3 rst_n = 1'b0;
      #1;
      cmp("t5_period", 32'(period), 0);
      cmp("t5_high", 32'(high_time), 0);
      cmp("t5_pv", 32'(period_valid), 0);
      cmp("t5_locked", 32'(locked), 0);
      cmp("t5_err", 32'(err), 0);
      @(negedge clk); rst_n = 1'b1;
      blink(1, 1); blink(0, 4); #2;
      p0 = pulses;
      blink(1, 4); blink(0, 4); blink(1, 1); blink(1, 1); #2;
      cmp("t5_pulses", 32'(pulses - p0), 1);
      cmp("t5_high_after", 32'(high_time), 4);

      // randomized waveforms, enable drops, dropouts and clears
      rnd_clr = 1'b1;
      for (int i = 0; i < 200; i++) begin
         int r, h, l;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            @(negedge clk); en = 1'b0; err_clr = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk); en = 1'b1;
         end else if (r == 1) begin
            blink(0, $urandom_range(28, 40));
         end
         h = $urandom_range(1, 6);
         l = ($urandom_range(0, 1) == 1) ? (EXP_PERIOD - h) : $urandom_range(1, 6);
         blink(1, h);
         blink(0, l);
      end
      rnd_clr = 1'b0;
      blink(0, 3);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
